// File: rtl/stream_xor_decoder.sv
// Keystream consumer: pops one FIFO byte per ciphertext byte and emits din ^ keystream
// as plaintext over a valid/ready output, framed by start/done with abort support.
module stream_xor_decoder #(
    parameter int DW    = 8,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             abort,
    input  logic [DW-1:0]    ks_dout,
    input  logic             ks_empty,
    output logic             ks_rd,
    input  logic [DW-1:0]    din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [DW-1:0]    dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [LEN_W-1:0] byte_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_XOR,
        S_OUT,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len;
    logic [DW-1:0]    ks_reg;
    logic             kill;

    // abort only ends an active frame; IDLE and DONE already head to idle
    always_comb begin
        kill = abort && (state inside {S_FETCH, S_WAIT, S_XOR, S_OUT});
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ks_rd     = 1'b0;
        din_ready = 1'b0;
        if (kill) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start && msg_len != '0) state_nxt = S_FETCH;
                S_FETCH: if (!ks_empty) begin
                    ks_rd     = 1'b1;
                    state_nxt = S_WAIT;
                end
                S_WAIT:  state_nxt = S_XOR;
                S_XOR: begin
                    din_ready = 1'b1;
                    if (din_valid) state_nxt = S_OUT;
                end
                S_OUT:   if (dout_ready) state_nxt = (byte_cnt == len) ? S_DONE : S_FETCH;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
        // strobes must stay low while reset is held, whatever the state register says
        if (rst) begin
            ks_rd     = 1'b0;
            din_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len        <= '0;
            ks_reg     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            byte_cnt   <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            if (kill) begin
                aborted    <= 1'b1;
                busy       <= 1'b0;
                dout_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        byte_cnt <= '0;
                        if (msg_len != '0) begin
                            len  <= msg_len;
                            busy <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                    S_WAIT: ks_reg <= ks_dout;
                    S_XOR: if (din_valid) begin
                        dout       <= din ^ ks_reg;
                        dout_valid <= 1'b1;
                        byte_cnt   <= byte_cnt + LEN_W'(1);
                    end
                    // done is raised here so it is high during the DONE cycle
                    S_OUT: if (dout_ready) begin
                        dout_valid <= 1'b0;
                        if (byte_cnt == len) done <= 1'b1;
                    end
                    S_DONE: busy <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/stream_xor_decoder.md
Name: stream_xor_decoder

Overview:
- Consumer end of the keystream path. It pops keystream bytes from the keystream FIFO and XORs each one with an incoming ciphertext byte.
- Each plaintext byte goes out on a valid/ready interface.
- Works on frames of msg_len bytes, started by a start pulse, with a done pulse at frame end.
- It is the decryption counterpart of the cipher+FIFO encryption path; the same keystream byte order is consumed.

Parameters:
- DW, 8, data/keystream byte width
- LEN_W, 16, width of the frame length and the byte counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle frame start request
- msg_len  in  LEN_W  frame length in bytes, sampled on accepted start
- abort  in  1  terminate current frame
- ks_dout  in  DW  keystream byte from FIFO; valid the cycle after ks_rd
- ks_empty  in  1  FIFO empty flag
- ks_rd  out  1  FIFO read strobe, one cycle per byte
- din  in  DW  ciphertext byte
- din_valid  in  1  din valid
- din_ready  out  1  block accepts din this cycle
- dout  out  DW  plaintext byte
- dout_valid  out  1  dout valid
- dout_ready  in  1  sink accepts dout
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at normal frame end
- aborted  out  1  one-cycle pulse when abort ends a frame
- byte_cnt  out  LEN_W  bytes delivered in the current or last frame

Behaviour:
- Reset: state=IDLE. ks_rd, din_ready, dout_valid, busy, done and aborted are all 0. dout=0, byte_cnt=0, and the internal len and ks_reg are 0.
- The clock and reset are decided: one clock, rst synchronous active-high. Reset mid-frame discards everything, and ks_rd is 0 in the reset cycle.
- IDLE:
  - start=1 and msg_len!=0: latch len<=msg_len, clear byte_cnt, busy<=1, go to FETCH.
  - start=1 and msg_len==0: done=1 next cycle, byte_cnt=0, stay in IDLE, no FIFO access.
- FETCH: ks_rd=1 combinationally while !ks_empty, then go to WAIT. ks_rd is never asserted when ks_empty=1; the block stalls in FETCH.
- WAIT: ks_reg<=ks_dout, go to XOR. Exactly one keystream byte is consumed per output byte.
- XOR:
  - din_ready=1.
  - On din_valid: dout<=din^ks_reg, dout_valid<=1, byte_cnt<=byte_cnt+1, go to OUT.
- OUT:
  - dout and dout_valid are held stable until dout_ready=1.
  - On the handshake, dout_valid<=0.
  - If byte_cnt==len, go to DONE; else go to FETCH.
- DONE: done=1 for exactly one cycle, busy<=0, go to IDLE. byte_cnt holds its value until the next accepted start.
- Throughput: at most 1 byte per 4 cycles. Latency from din handshake to dout_valid is 1 cycle.
- start while busy is ignored, with no effect on len or byte_cnt.
- abort:
  - Any state except IDLE/DONE goes to IDLE next cycle. aborted=1 for one cycle, busy<=0, dout_valid<=0, byte_cnt is kept.
  - abort in WAIT still completes the FIFO pop: the byte is discarded and ks_reg is not updated.
  - abort has priority over start, din and dout handshakes in the same cycle.
- byte_cnt wraps only if len = 2^LEN_W-1 is exceeded, which is impossible because the frame ends at len.
- In XOR, din_valid=0 means wait indefinitely. In OUT, dout_ready=0 means hold indefinitely.

Test Plan:
- Reset: rst=1 for 2 cycles mid-frame -> all outputs 0, state IDLE, ks_rd never high during reset.
- Basic frame: msg_len=3, FIFO holds A5,3C,FF, din=00,3C,0F with dout_ready=1 -> dout=A5,00,F0; 3 ks_rd pulses; done one cycle after the last handshake; byte_cnt=3.
- FIFO empty stall: ks_empty=1 for 10 cycles after start -> ks_rd=0 and din_ready=0 throughout. When ks_empty drops, 1 ks_rd pulse, correct XOR result.
- Backpressure: dout_ready=0 for 5 cycles with dout=5A valid -> dout stable at 5A and dout_valid=1, no ks_rd, din_ready=0 until the handshake.
- Zero length and busy start:
  - msg_len=0 -> done pulse, no ks_rd, byte_cnt=0.
  - start with msg_len=9 during a 2-byte frame -> ignored, done after 2 bytes.
- Abort: abort in WAIT after byte 1 of a 4-byte frame -> aborted pulse, busy=0, byte_cnt=1, FIFO popped exactly 2 bytes total. A new start then processes normally.
